// File: rtl/dm_pkg.sv
// rtl/dm_pkg.sv - shared types and constants for the dm_responder data memory.
package dm_pkg;

   localparam int DM_DEPTH_DEFAULT = 1024;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_RSVD = 2'b11
   } size_e;

   typedef enum logic [1:0] {
      IDLE,
      ACC_LO,
      ACC_HI,
      RESP
   } state_e;

   // Byte lanes touched by an access of the given size at offset 0.
   function automatic logic [3:0] size_lanes(size_e s);
      case (s)
         SZ_BYTE: size_lanes = 4'b0001;
         SZ_HALF: size_lanes = 4'b0011;
         SZ_WORD: size_lanes = 4'b1111;
         default: size_lanes = 4'b0000;
      endcase
   endfunction

endpackage

// File: rtl/dm_lane_align.sv
// rtl/dm_lane_align.sv - byte masks, write-lane shift and read realignment
// over a two-word window (lo word at addr[31:2], hi word just above it).
module dm_lane_align
   import dm_pkg::*;
(
   input  size_e       size,
   input  logic [1:0]  offset,
   input  logic [31:0] wdata,
   input  logic [31:0] rd_lo,
   input  logic [31:0] rd_hi,
   output logic [3:0]  mask_lo,
   output logic [3:0]  mask_hi,
   output logic [31:0] wdata_lo,
   output logic [31:0] wdata_hi,
   output logic [31:0] rdata,
   output logic        misaligned
);

   logic [3:0]  lanes;
   logic [7:0]  mask8;
   logic [63:0] wide_w;
   logic [63:0] wide_r;
   logic [31:0] keep;

   always_comb begin
      lanes  = size_lanes(size);
      mask8  = {4'b0000, lanes} << offset;
      wide_w = {32'h0, wdata} << {offset, 3'b000};
      wide_r = {rd_hi, rd_lo} >> {offset, 3'b000};
      keep   = '0;
      for (int b = 0; b < 4; b++) begin
         keep[8*b +: 8] = {8{lanes[b]}};
      end
      mask_lo    = mask8[3:0];
      mask_hi    = mask8[7:4];
      wdata_lo   = wide_w[31:0];
      wdata_hi   = wide_w[63:32];
      rdata      = wide_r[31:0] & keep;
      misaligned = ((size == SZ_HALF) && offset[0]) ||
                   ((size == SZ_WORD) && (offset != 2'b00));
   end

endmodule

// File: rtl/dm_responder.sv
// rtl/dm_responder.sv - request/response data memory with byte/half/word access.
// DM_MISALIGN_EN enables split word-crossing accesses; otherwise misaligned ones are rejected.
module dm_responder
   import dm_pkg::*;
#(
   parameter int DEPTH_WORDS = DM_DEPTH_DEFAULT
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_wen,
   input  logic [1:0]  req_size,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [31:0] DEPTH32 = 32'(DEPTH_WORDS);

   logic [31:0] mem [DEPTH_WORDS];

   state_e      state, state_d;
   logic        wen_q;
   size_e       size_q;
   logic [31:0] addr_q, wdata_q;
   logic [31:0] rd_lo, rd_hi;
   logic        rsp_valid_q, rsp_err_q;
   logic [31:0] rsp_rdata_q;

   logic [29:0] idx_lo;
   logic [30:0] idx_hi;
   logic [3:0]  mask_lo, mask_hi;
   logic [31:0] wdata_lo, wdata_hi, align_rdata;
   logic        misaligned, split, reject_misalign, acc_err;
   logic        lo_we, hi_we;

   dm_lane_align u_align (
      .size       (size_q),
      .offset     (addr_q[1:0]),
      .wdata      (wdata_q),
      .rd_lo      (rd_lo),
      .rd_hi      (rd_hi),
      .mask_lo    (mask_lo),
      .mask_hi    (mask_hi),
      .wdata_lo   (wdata_lo),
      .wdata_hi   (wdata_hi),
      .rdata      (align_rdata),
      .misaligned (misaligned)
   );

`ifdef DM_MISALIGN_EN
   assign reject_misalign = 1'b0;
`else
   assign reject_misalign = misaligned;
`endif

   // Hi index is one bit wider so the top word never wraps to word 0.
   assign idx_lo  = addr_q[31:2];
   assign idx_hi  = {1'b0, idx_lo} + 31'd1;
   assign split   = |mask_hi;
   assign acc_err = (size_q == SZ_RSVD) || ({2'b00, idx_lo} >= DEPTH32) ||
                    (split && ({1'b0, idx_hi} >= DEPTH32)) || reject_misalign;

   always_comb begin
      state_d   = state;
      req_ready = 1'b0;
      lo_we     = 1'b0;
      hi_we     = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) state_d = ACC_LO;
         end
         ACC_LO: begin
            lo_we = wen_q && !acc_err;
`ifdef DM_MISALIGN_EN
            state_d = (split && !acc_err) ? ACC_HI : RESP;
`else
            state_d = RESP;
`endif
         end
         ACC_HI: begin
            hi_we   = wen_q && !acc_err;
            state_d = RESP;
         end
         RESP: begin
            if (rsp_valid_q && rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         state <= state_d;
         if (req_valid && req_ready) begin
            wen_q   <= req_wen;
            size_q  <= size_e'(req_size);
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
         end
         // First RESP cycle registers the realigned data; the second presents it.
         if (state == RESP) begin
            if (!rsp_valid_q) begin
               rsp_valid_q <= 1'b1;
               rsp_err_q   <= acc_err;
               rsp_rdata_q <= (acc_err || wen_q) ? 32'h0 : align_rdata;
            end else if (rsp_ready) begin
               rsp_valid_q <= 1'b0;
               rsp_err_q   <= 1'b0;
               rsp_rdata_q <= '0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (state == ACC_LO) rd_lo <= mem[idx_lo[AW-1:0]];
      if (state == ACC_HI) rd_hi <= mem[idx_hi[AW-1:0]];
      for (int b = 0; b < 4; b++) begin
         if (!rst && lo_we && mask_lo[b])
            mem[idx_lo[AW-1:0]][8*b +: 8] <= wdata_lo[8*b +: 8];
         if (!rst && hi_we && mask_hi[b])
            mem[idx_hi[AW-1:0]][8*b +: 8] <= wdata_hi[8*b +: 8];
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dm_responder.sv
// tb/tb_dm_responder.sv - randomized self-checking bench for dm_responder
// against a byte-addressed reference memory; honours DM_MISALIGN_EN.
module tb_dm_responder;

   localparam int DEPTH = 64;
   localparam int NBYTES = 4 * DEPTH;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_wen = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b1;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   logic [7:0]  ref_mem [NBYTES];
   int          tests = 0;
   int          fails = 0;

   dm_responder #(.DEPTH_WORDS(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_wen   (req_wen),
      .req_size  (req_size),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: byte-addressed memory, rules applied to byte ranges.
   task automatic model_access(input logic wen, input logic [1:0] size, input logic [31:0] addr,
                               input logic [31:0] wdata, output logic err,
                               output logic [31:0] rd, output int lat);
      longint a, last;
      int n;
      n    = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
      a    = longint'(addr);
      last = a + n - 1;
      err  = (size == 2'b11) || ((a >> 2) >= DEPTH) || ((last >> 2) >= DEPTH);
`ifndef DM_MISALIGN_EN
      if ((a % n) != 0) err = 1'b1;
`endif
      lat = (!err && ((a % 4) + n > 4)) ? 3 : 2;
      rd  = 32'h0;
      if (!err) begin
         for (int i = 0; i < n; i++) begin
            if (wen) ref_mem[int'(a) + i] = wdata[8*i +: 8];
            else     rd[8*i +: 8] = ref_mem[int'(a) + i];
         end
      end
   endtask

   // Called at posedge+1 with the DUT idle; hold = cycles rsp_ready stays low.
   task automatic txn(input string tag, input logic wen, input logic [1:0] size,
                      input logic [31:0] addr, input logic [31:0] wdata, input int hold);
      logic        e_err;
      logic [31:0] e_rd;
      int          e_lat, lat;
      model_access(wen, size, addr, wdata, e_err, e_rd, e_lat);
      check({tag, " req_ready"}, 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_wen = wen; req_size = size; req_addr = addr; req_wdata = wdata;
      rsp_ready = (hold == 0);
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = 0;
      while (!rsp_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      check({tag, " latency"}, 32'(lat), 32'(e_lat));
      if (!rsp_valid) begin
         rsp_ready = 1'b1;
         return;
      end
      check({tag, " rdata"}, rsp_rdata, e_rd);
      check({tag, " err"}, 32'(rsp_err), 32'(e_err));
      for (int k = 0; k < hold; k++) begin
         @(posedge clk); #1;
         check({tag, " hold valid"}, 32'(rsp_valid), 32'd1);
         check({tag, " hold rdata"}, rsp_rdata, e_rd);
         check({tag, " hold err"}, 32'(rsp_err), 32'(e_err));
         check({tag, " hold req_ready"}, 32'(req_ready), 32'd0);
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      check({tag, " rsp drop"}, 32'(rsp_valid), 32'd0);
   endtask

   initial begin
      logic [1:0]  sz;
      logic [31:0] ad;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check("reset req_ready", 32'(req_ready), 32'd1);
      check("reset rsp_valid", 32'(rsp_valid), 32'd0);
      check("reset rsp_rdata", rsp_rdata, 32'h0);
      check("reset rsp_err", 32'(rsp_err), 32'd0);

      for (int w = 0; w < DEPTH; w++) txn("init", 1'b1, 2'b10, 32'(4 * w), $urandom, 0);

      txn("wr word 10", 1'b1, 2'b10, 32'h10, 32'hDEADBEEF, 0);
      txn("rd word 10", 1'b0, 2'b10, 32'h10, 32'h0, 0);
      txn("wr byte 11", 1'b1, 2'b00, 32'h11, 32'h000000AA, 0);
      txn("rd word 10b", 1'b0, 2'b10, 32'h10, 32'h0, 0);
      txn("wr word 0e", 1'b1, 2'b10, 32'h0E, 32'h11223344, 0);
      txn("rd half 0e", 1'b0, 2'b01, 32'h0E, 32'h0, 0);
      txn("rd half 10", 1'b0, 2'b01, 32'h10, 32'h0, 0);
      txn("rd word 0c", 1'b0, 2'b10, 32'h0C, 32'h0, 0);
      txn("rd word 10c", 1'b0, 2'b10, 32'h10, 32'h0, 0);
      txn("wr top-2", 1'b1, 2'b10, 32'(NBYTES - 2), 32'hCAFEF00D, 0);
      txn("rd last", 1'b0, 2'b10, 32'(NBYTES - 4), 32'h0, 0);
      txn("rd past end", 1'b0, 2'b10, 32'(NBYTES), 32'h0, 0);
      txn("rd wrap", 1'b0, 2'b01, 32'hFFFFFFFF, 32'h0, 0);
      txn("size 11", 1'b1, 2'b11, 32'h20, 32'h12345678, 0);
      txn("rd after rsvd", 1'b0, 2'b10, 32'h20, 32'h0, 0);
      txn("backpressure", 1'b0, 2'b10, 32'h10, 32'h0, 5);

      req_valid = 1'b1; req_wen = 1'b0; req_size = 2'b10; req_addr = 32'h10;
      @(posedge clk); #1;
      req_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("mid rst rsp_valid", 32'(rsp_valid), 32'd0);
      check("mid rst req_ready", 32'(req_ready), 32'd1);
      txn("after rst", 1'b0, 2'b10, 32'h10, 32'h0, 0);

      for (int i = 0; i < 200; i++) begin
         sz = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
         ad = ($urandom_range(0, 19) == 0) ? (32'hFFFFFFFC | 32'($urandom_range(0, 3)))
                                           : 32'($urandom_range(0, NBYTES + 7));
         txn("random", 1'($urandom_range(0, 1)), sz, ad, $urandom, $urandom_range(0, 2));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
